mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and consumes its EXE/MEM registers (ALU result, zero flag, branch target, rs2 store data, destination register).
- Drives a request/grant/rvalid data-memory bus and stalls the upstream pipeline while an access is outstanding.
- Formats load data with byte/halfword extraction and sign extension, generates store byte enables, resolves branches, and registers the MEM/WB outputs.

Parameters:
MAX_WAIT, 15, cycles allowed in REQ or WAIT before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
valid_exe_mem  in  1  EXE/MEM slot holds a real instruction
alu_result_exe_mem  in  32  effective address or ALU result
zero_exe_mem  in  1  ALU zero flag
PC_branch_exe_mem  in  32  branch target
rs2_exe_mem  in  32  store data
write_reg_exe_mem  in  5  destination register
reg_write_exe_mem  in  1  instruction writes rd
mem_read_exe_mem  in  1  load
mem_write_exe_mem  in  1  store
branch_exe_mem  in  1  conditional branch
funct3_exe_mem  in  3  access size/sign
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, bits [1:0] = 0
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
stall_mem  out  1  upstream must hold its EXE/MEM registers
pc_src_mem  out  1  branch taken
PC_branch_mem  out  32  branch target, passthrough
valid_mem_wb  out  1  MEM/WB slot valid
alu_result_mem_wb  out  32  registered ALU result
read_data_mem_wb  out  32  formatted load data
write_reg_mem_wb  out  5  destination register
reg_write_mem_wb  out  1  write enable (suppressed on error)
mem_to_reg_mem_wb  out  1  writeback selects read_data
err_mem_wb  out  1  misaligned access, illegal funct3, or timeout

Behaviour:
- Reset values: all *_mem_wb outputs 0; dmem_req/dmem_we 0; dmem_addr/be/wdata 0; state IDLE.
- Reset is asynchronous: it drops dmem_req immediately, mid-transaction included. A dmem_rvalid arriving after reset is ignored.
- mem_op = valid_exe_mem & (mem_read_exe_mem | mem_write_exe_mem). Load and store asserted together is treated as a store.
- pc_src_mem = valid_exe_mem & branch_exe_mem & zero_exe_mem (combinational). PC_branch_mem = PC_branch_exe_mem.
- IDLE:
  - No mem_op: stall_mem=0; MEM/WB captures at the next edge (1-cycle latency).
  - Error op: stall_mem=0; completes immediately with no bus request.
  - Legal mem_op: stall_mem=1; next state REQ.
- REQ: dmem_req=1 with address, we, be and wdata held stable until dmem_gnt.
  - Store with gnt: stall_mem=0, MEM/WB captures, next IDLE.
  - Load with gnt: next WAIT, stall_mem=1.
- WAIT: stall_mem=1 until dmem_rvalid. On rvalid: stall_mem=0, read_data_mem_wb = formatted dmem_rdata, next IDLE.
- Bus rule: dmem_rvalid is never returned in the gnt cycle. rvalid seen in IDLE or REQ is ignored.
- Latency from a valid EXE/MEM op: store with 0-wait gnt = 2 cycles; load with 0-wait gnt and next-cycle rvalid = 3 cycles.
- funct3 encodings:
  - 000 byte, sign-extended
  - 001 half, sign-extended
  - 010 word
  - 100 byte, zero-extended
  - 101 half, zero-extended
  - Loads accept all five; stores accept 000/001/010 only.
  - Any other funct3 is an error.
- Byte enables: byte = 0001<<a[1:0]; half = 0011<<{a[1],1'b0}; word = 1111.
- wdata: byte replicated x4, half replicated x2, word unchanged.
- Misaligned = half with a[0]=1, or word with a[1:0]!=0. Misalignment or illegal funct3 gives err_mem_wb=1, reg_write_mem_wb=0, and no bus request.
- Load extraction selects the lane given by a[1:0], then sign- or zero-extends.
- mem_to_reg_mem_wb = load & ~err. A bubble (valid_exe_mem=0) gives valid_mem_wb=0 and reg_write_mem_wb=0.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 4-bit+ wait counter clears on entry to REQ/WAIT and increments each cycle in those states.
  - When the count reaches MAX_WAIT with no gnt/rvalid: drop dmem_req, complete with err_mem_wb=1 and reg_write_mem_wb=0, stall_mem=0, next IDLE.
  - A late rvalid after abort is ignored.
- Undefined: no counter; the stage waits indefinitely; err comes only from misalignment or illegal funct3.

Decomposition:
- Package mem_pkg holds the funct3 localparams (F3_LB..F3_LHU), the state encoding (IDLE/REQ/WAIT) and the byte-enable base constants.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], funct3; output the extended 32-bit load value.

Test Plan:
- ALU op, valid=1, alu_result=0x1234, rd=5, no mem -> next cycle alu_result_mem_wb=0x1234, write_reg=5, reg_write=1, stall_mem never 1.
- SB, addr=0x103, rs2=0xAB, gnt in first REQ cycle -> dmem_addr=0x100, be=1000, wdata=0xABABABAB, we=1; stall high 1 cycle.
- LB, addr=0x102, rdata=0x00800000, gnt after 2 waits, rvalid 1 cycle later -> read_data=0xFFFFFF80; LBU of the same -> 0x00000080; stall released exactly on the rvalid cycle.
- LW, addr=0x202 -> no dmem_req, err_mem_wb=1, reg_write_mem_wb=0, stall_mem=0.
- Branch, zero=1, PC_branch=0x400 -> pc_src_mem=1 same cycle; zero=0 -> pc_src_mem=0.
- rst asserted during WAIT, then rvalid -> dmem_req=0 immediately, state IDLE, rvalid ignored. With MEM_TIMEOUT_EN and gnt never asserted -> abort after 15 cycles with err=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: funct3 codes, FSM encoding,
// byte-enable base patterns and a funct3 legality helper.
// No logic of its own; imported by mem_stage and mem_load_align.
package mem_pkg;

  // Access size / sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Bus FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Byte-enable patterns before shifting into the addressed lane
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Loads accept all five encodings; stores only the three signed sizes.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = ~is_store;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/halfword lane from addr[1:0] and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  // Lane select followed by sign or zero extension; funct3[2] marks unsigned
  always_comb begin
    sext = ~funct3[2];
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3[1:0])
      2'b00:   load_data = {{24{sext & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{sext & half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the req/gnt/rvalid data bus, formats loads, registers MEM/WB.
// Latency: non-memory op 1 cycle; store 2 cycles with 0-wait gnt; load 3 cycles with next-cycle rvalid.
// Backpressure: stall_mem holds EXE/MEM while an access is outstanding. Optional abort via MEM_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_exe_mem,
  input  logic [31:0] alu_result_exe_mem,
  input  logic        zero_exe_mem,
  input  logic [31:0] PC_branch_exe_mem,
  input  logic [31:0] rs2_exe_mem,
  input  logic [4:0]  write_reg_exe_mem,
  input  logic        reg_write_exe_mem,
  input  logic        mem_read_exe_mem,
  input  logic        mem_write_exe_mem,
  input  logic        branch_exe_mem,
  input  logic [2:0]  funct3_exe_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        pc_src_mem,
  output logic [31:0] PC_branch_mem,
  output logic        valid_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [4:0]  write_reg_mem_wb,
  output logic        reg_write_mem_wb,
  output logic        mem_to_reg_mem_wb,
  output logic        err_mem_wb
);

  logic [1:0]  state_q, state_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;

  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regw_q, regw_d;
  logic        m2r_q, m2r_d;
  logic        err_q, err_d;

  logic        mem_op, is_store, is_load, misaligned, op_err;
  logic [1:0]  a_lo;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_val;
  logic        timeout;
  logic        complete, fail, bus_load, bus_clear;

  assign a_lo = alu_result_exe_mem[1:0];

  mem_load_align u_align (
    .rdata     (dmem_rdata),
    .addr      (a_lo),
    .funct3    (funct3_exe_mem),
    .load_data (load_val)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WCNT_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout = (wait_cnt_q == WCNT_W'(MAX_WAIT));

  // Counter restarts on every entry into REQ or WAIT, counts while there
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d == ST_REQ || state_d == ST_WAIT) && state_d != state_q)
      wait_cnt_d = '0;
    else if (state_q == ST_REQ || state_q == ST_WAIT)
      wait_cnt_d = wait_cnt_q + WCNT_W'(1);
  end

  // Wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  localparam int unsigned UNUSED_MAX_WAIT = MAX_WAIT;
  assign timeout = 1'b0;
`endif

  // Decode: op class, lane-shifted byte enables, replicated store data, alignment
  always_comb begin
    is_store   = mem_write_exe_mem;
    is_load    = mem_read_exe_mem & ~mem_write_exe_mem;
    mem_op     = valid_exe_mem & (mem_read_exe_mem | mem_write_exe_mem);
    misaligned = 1'b0;
    be_c       = BE_WORD;
    wdata_c    = rs2_exe_mem;
    case (funct3_exe_mem[1:0])
      2'b00: begin
        be_c    = BE_BYTE << a_lo;
        wdata_c = {4{rs2_exe_mem[7:0]}};
      end
      2'b01: begin
        be_c       = BE_HALF << {a_lo[1], 1'b0};
        wdata_c    = {2{rs2_exe_mem[15:0]}};
        misaligned = a_lo[0];
      end
      default: misaligned = |a_lo;
    endcase
    op_err = mem_op & (~f3_legal(funct3_exe_mem, is_store) | misaligned);
  end

  // Bus FSM: decides stall, completion and when the request registers load or clear
  always_comb begin
    state_d   = state_q;
    stall_mem = 1'b0;
    complete  = 1'b0;
    fail      = 1'b0;
    bus_load  = 1'b0;
    bus_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !op_err) begin
          stall_mem = 1'b1;
          bus_load  = 1'b1;
          state_d   = ST_REQ;
        end else begin
          complete = 1'b1;
          fail     = op_err;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          bus_clear = 1'b1;
          if (is_store) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            stall_mem = 1'b1;
            state_d   = ST_WAIT;
          end
        end else if (timeout) begin
          bus_clear = 1'b1;
          complete  = 1'b1;
          fail      = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall_mem = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout) begin
          complete = 1'b1;
          fail     = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers hold address/we/be/wdata steady for the whole REQ phase
  always_comb begin
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    if (bus_load) begin
      dmem_we_d    = is_store;
      dmem_addr_d  = {alu_result_exe_mem[31:2], 2'b00};
      dmem_be_d    = be_c;
      dmem_wdata_d = is_store ? wdata_c : 32'd0;
    end else if (bus_clear) begin
      dmem_we_d    = 1'b0;
      dmem_addr_d  = 32'd0;
      dmem_be_d    = 4'd0;
      dmem_wdata_d = 32'd0;
    end
  end

  // MEM/WB next values: capture on completion, otherwise insert a bubble
  always_comb begin
    valid_d = 1'b0;
    alu_d   = 32'd0;
    rdata_d = 32'd0;
    wreg_d  = 5'd0;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    err_d   = 1'b0;
    if (complete) begin
      valid_d = valid_exe_mem;
      alu_d   = alu_result_exe_mem;
      wreg_d  = write_reg_exe_mem;
      regw_d  = valid_exe_mem & reg_write_exe_mem & ~fail;
      m2r_d   = mem_op & is_load & ~fail;
      err_d   = fail;
      if (state_q == ST_WAIT && dmem_rvalid) rdata_d = load_val;
    end
  end

  // FSM, bus request and MEM/WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      valid_q      <= 1'b0;
      alu_q        <= 32'd0;
      rdata_q      <= 32'd0;
      wreg_q       <= 5'd0;
      regw_q       <= 1'b0;
      m2r_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      valid_q      <= valid_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      wreg_q       <= wreg_d;
      regw_q       <= regw_d;
      m2r_q        <= m2r_d;
      err_q        <= err_d;
    end
  end

  // Request is decoded from state so an async reset withdraws it at once
  assign dmem_req   = (state_q == ST_REQ);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

  assign pc_src_mem    = valid_exe_mem & branch_exe_mem & zero_exe_mem;
  assign PC_branch_mem = PC_branch_exe_mem;

  assign valid_mem_wb      = valid_q;
  assign alu_result_mem_wb = alu_q;
  assign read_data_mem_wb  = rdata_q;
  assign write_reg_mem_wb  = wreg_q;
  assign reg_write_mem_wb  = regw_q;
  assign mem_to_reg_mem_wb = m2r_q;
  assign err_mem_wb        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU passthrough, stores, loads with waits, errors, branches, reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later or after the next edge.
// Optional MEM_TIMEOUT_EN section exercises the abort path.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_exe_mem, zero_exe_mem, reg_write_exe_mem;
  logic        mem_read_exe_mem, mem_write_exe_mem, branch_exe_mem;
  logic [31:0] alu_result_exe_mem, PC_branch_exe_mem, rs2_exe_mem;
  logic [4:0]  write_reg_exe_mem;
  logic [2:0]  funct3_exe_mem;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem, pc_src_mem;
  logic [31:0] PC_branch_mem;
  logic        valid_mem_wb, reg_write_mem_wb, mem_to_reg_mem_wb, err_mem_wb;
  logic [31:0] alu_result_mem_wb, read_data_mem_wb;
  logic [4:0]  write_reg_mem_wb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .valid_exe_mem(valid_exe_mem), .alu_result_exe_mem(alu_result_exe_mem),
    .zero_exe_mem(zero_exe_mem), .PC_branch_exe_mem(PC_branch_exe_mem),
    .rs2_exe_mem(rs2_exe_mem), .write_reg_exe_mem(write_reg_exe_mem),
    .reg_write_exe_mem(reg_write_exe_mem), .mem_read_exe_mem(mem_read_exe_mem),
    .mem_write_exe_mem(mem_write_exe_mem), .branch_exe_mem(branch_exe_mem),
    .funct3_exe_mem(funct3_exe_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .pc_src_mem(pc_src_mem), .PC_branch_mem(PC_branch_mem),
    .valid_mem_wb(valid_mem_wb), .alu_result_mem_wb(alu_result_mem_wb),
    .read_data_mem_wb(read_data_mem_wb), .write_reg_mem_wb(write_reg_mem_wb),
    .reg_write_mem_wb(reg_write_mem_wb), .mem_to_reg_mem_wb(mem_to_reg_mem_wb),
    .err_mem_wb(err_mem_wb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_exe_mem = 0; alu_result_exe_mem = 0; zero_exe_mem = 0;
    PC_branch_exe_mem = 0; rs2_exe_mem = 0; write_reg_exe_mem = 0;
    reg_write_exe_mem = 0; mem_read_exe_mem = 0; mem_write_exe_mem = 0;
    branch_exe_mem = 0; funct3_exe_mem = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdst);
    valid_exe_mem = 1; mem_read_exe_mem = rd; mem_write_exe_mem = wr;
    funct3_exe_mem = f3; alu_result_exe_mem = addr; rs2_exe_mem = wd;
    write_reg_exe_mem = rdst; reg_write_exe_mem = rd & ~wr;
  endtask

  initial begin
    idle_inputs();
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

    // Reset state
    #1;
    check("rst_valid", valid_mem_wb, 0);
    check("rst_req", dmem_req, 0);
    check("rst_regw", reg_write_mem_wb, 0);
    check("rst_addr", dmem_addr, 0);
    tick(); tick();
    rst = 0;

    // Plain ALU op: one-cycle capture, no stall
    valid_exe_mem = 1; alu_result_exe_mem = 32'h1234; write_reg_exe_mem = 5;
    reg_write_exe_mem = 1;
    #1 check("alu_stall", stall_mem, 0);
    tick();
    check("alu_res", alu_result_mem_wb, 32'h1234);
    check("alu_rd", write_reg_mem_wb, 5);
    check("alu_regw", reg_write_mem_wb, 1);
    check("alu_m2r", mem_to_reg_mem_wb, 0);
    idle_inputs();

    // SB at 0x103, gnt in the first REQ cycle
    mem_op(0, 1, 3'b000, 32'h103, 32'hAB, 0);
    #1 check("sb_stall_idle", stall_mem, 1);
    check("sb_noreq_idle", dmem_req, 0);
    tick();
    check("sb_req", dmem_req, 1);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_we", dmem_we, 1);
    dmem_gnt = 1;
    #1 check("sb_stall_gnt", stall_mem, 0);
    tick();
    dmem_gnt = 0; idle_inputs();
    check("sb_wb_valid", valid_mem_wb, 1);
    check("sb_wb_regw", reg_write_mem_wb, 0);
    check("sb_wb_err", err_mem_wb, 0);
    check("sb_req_done", dmem_req, 0);

    // SH at 0x202: upper half lane, data replicated
    mem_op(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0);
    tick();
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    check("sh_addr", dmem_addr, 32'h200);
    dmem_gnt = 1; tick(); dmem_gnt = 0; idle_inputs();
    check("sh_wb_err", err_mem_wb, 0);

    // LB at 0x102, two REQ cycles without gnt, rvalid one cycle after gnt
    mem_op(1, 0, 3'b000, 32'h102, 0, 7);
    tick();
    check("lb_req1", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_be", dmem_be, 4'b0100);
    tick();
    check("lb_req2_stall", stall_mem, 1);
    check("lb_bubble", valid_mem_wb, 0);
    tick();
    check("lb_req3", dmem_req, 1);
    dmem_gnt = 1;
    #1 check("lb_stall_gnt", stall_mem, 1);
    tick();
    dmem_gnt = 0;
    check("lb_wait_req", dmem_req, 0);
    check("lb_wait_stall", stall_mem, 1);
    dmem_rvalid = 1; dmem_rdata = 32'h00800000;
    #1 check("lb_stall_rvalid", stall_mem, 0);
    tick();
    dmem_rvalid = 0;
    check("lb_data", read_data_mem_wb, 32'hFFFFFF80);
    check("lb_regw", reg_write_mem_wb, 1);
    check("lb_m2r", mem_to_reg_mem_wb, 1);
    check("lb_rd", write_reg_mem_wb, 7);

    // LBU of the same word, 0-wait gnt: result appears 3 cycles after issue
    funct3_exe_mem = 3'b100;
    tick(); dmem_gnt = 1;
    tick(); dmem_gnt = 0; dmem_rvalid = 1;
    tick(); dmem_rvalid = 0; idle_inputs();
    check("lbu_data", read_data_mem_wb, 32'h00000080);
    check("lbu_valid", valid_mem_wb, 1);

    // LH at 0x102 sign-extends the upper half
    mem_op(1, 0, 3'b001, 32'h102, 0, 9);
    tick(); dmem_gnt = 1;
    tick(); dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80010000;
    tick(); dmem_rvalid = 0; idle_inputs();
    check("lh_data", read_data_mem_wb, 32'hFFFF8001);

    // Misaligned LW: error, no bus request, no stall
    mem_op(1, 0, 3'b010, 32'h202, 0, 3);
    #1 check("lwmis_stall", stall_mem, 0);
    tick();
    check("lwmis_req", dmem_req, 0);
    check("lwmis_err", err_mem_wb, 1);
    check("lwmis_regw", reg_write_mem_wb, 0);
    check("lwmis_m2r", mem_to_reg_mem_wb, 0);
    idle_inputs();

    // Store with an unsigned size code is illegal
    mem_op(0, 1, 3'b100, 32'h100, 32'h55, 0);
    #1 check("sbu_stall", stall_mem, 0);
    tick();
    check("sbu_err", err_mem_wb, 1);
    check("sbu_req", dmem_req, 0);
    idle_inputs();

    // Branch resolution is combinational
    valid_exe_mem = 1; branch_exe_mem = 1; zero_exe_mem = 1; PC_branch_exe_mem = 32'h400;
    #1 check("br_taken", pc_src_mem, 1);
    check("br_target", PC_branch_mem, 32'h400);
    zero_exe_mem = 0;
    #1 check("br_not_taken", pc_src_mem, 0);
    valid_exe_mem = 0; zero_exe_mem = 1;
    #1 check("br_bubble", pc_src_mem, 0);
    tick(); idle_inputs();

    // Reset mid-cycle during REQ withdraws the request before any edge
    mem_op(1, 0, 3'b010, 32'h300, 0, 4);
    tick();
    check("rreq_req", dmem_req, 1);
    #2 rst = 1;
    #1 check("rreq_req_drop", dmem_req, 0);
    idle_inputs();
    #1 check("rreq_stall", stall_mem, 0);
    tick(); rst = 0;

    // Reset during WAIT, then a stale rvalid is ignored
    mem_op(1, 0, 3'b010, 32'h300, 0, 4);
    tick(); dmem_gnt = 1;
    tick(); dmem_gnt = 0;
    check("rwait_stall", stall_mem, 1);
    idle_inputs();
    rst = 1;
    #1 check("rwait_req", dmem_req, 0);
    check("rwait_stall_rst", stall_mem, 0);
    check("rwait_valid", valid_mem_wb, 0);
    tick(); rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    #1 check("rwait_rv_stall", stall_mem, 0);
    tick(); dmem_rvalid = 0;
    check("rwait_rv_valid", valid_mem_wb, 0);
    check("rwait_rv_data", read_data_mem_wb, 0);

    // After reset the stage is idle: ALU op completes in one cycle
    valid_exe_mem = 1; alu_result_exe_mem = 32'h77; write_reg_exe_mem = 2; reg_write_exe_mem = 1;
    tick(); idle_inputs();
    check("post_rst_alu", alu_result_mem_wb, 32'h77);
    check("post_rst_regw", reg_write_mem_wb, 1);

`ifdef MEM_TIMEOUT_EN
    // gnt never comes: the stage aborts with an error
    begin
      int cyc;
      cyc = 0;
      mem_op(0, 1, 3'b010, 32'h40, 32'h1, 0);
      tick();
      while (stall_mem && cyc < 40) begin
        tick();
        cyc++;
      end
      check("to_bounded", (cyc < 40) ? 32'd1 : 32'd0, 1);
      check("to_cycles", cyc, 15);
      check("to_req_drop", dmem_req, 1);
      tick(); idle_inputs();
      check("to_err", err_mem_wb, 1);
      check("to_regw", reg_write_mem_wb, 0);
      check("to_req_gone", dmem_req, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
